serial_bus_arbiter: RTL and testbench
=====================================

Name: serial_bus_arbiter

Overview:
Central arbiter for the shared serial bus. It grants bus ownership to one of NUM_MASTERS bus masters at a time; the ext_interface bridge and on-chip masters are among them. Each master raises a request line, gets a one-hot grant, then signals activity through the wired b_util (bus utilizing) line. The arbiter revokes a grant when it is abandoned, idle too long, or finished, and serialises access with the slaves' shared slave_busy.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8)
TIMEOUT_LEN, 6, watchdog counter width in bits; timeout threshold TMAX = 2^TIMEOUT_LEN - 1
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  input  1  system clock
rstn  input  1  reset; asynchronous, active-low
m_request  input  NUM_MASTERS  per-master bus request; held high for the whole transaction
b_util  input  1  bus utilizing (resolved wired line), high while the owner drives the bus
slave_busy  input  1  resolved slave busy line
m_grant  output  NUM_MASTERS  one-hot grant, registered
owner_id  output  clog2(NUM_MASTERS)  index of current/last owner
arb_busy  output  1  high whenever state != IDLE
timeout_err  output  1  one-cycle pulse on watchdog-forced release

Behaviour:
- Reset (async, rstn low): state IDLE, m_grant 0, owner_id 0, timeout_err 0, rr_ptr 0, count 0. Outputs clear immediately, including mid-transaction.
- States: IDLE, GRANT_WAIT, OWNED, RELEASE. All outputs are registered.
- IDLE:
  - When |m_request and !slave_busy, select a winner, load owner_id, set m_grant bit, clear count, and go to GRANT_WAIT.
  - The grant appears on the edge after the request is first sampled (1-cycle latency).
  - If slave_busy is high, stay in IDLE regardless of requests.
- Winner selection:
  - PRIORITY_MODE=0: first requesting index scanning upward from rr_ptr, wrapping at NUM_MASTERS-1 to 0.
  - PRIORITY_MODE=1: lowest requesting index; rr_ptr is ignored.
- GRANT_WAIT, priority order evaluated each cycle:
  1. !m_request[owner]: go to RELEASE (abandon, no error).
  2. b_util high: go to OWNED and clear count.
  3. count == TMAX: go to RELEASE and pulse timeout_err.
  4. Otherwise count++.
  - Grant therefore stays high for at most 2^TIMEOUT_LEN cycles without bus activity.
- OWNED:
  - !m_request[owner]: go to RELEASE.
  - Otherwise, if b_util is high, clear count.
  - Otherwise, if count == TMAX, go to RELEASE and pulse timeout_err.
  - Otherwise count++. This is the idle watchdog: b_util low for 2^TIMEOUT_LEN consecutive cycles.
- Entry to RELEASE (same edge): m_grant cleared to 0, and rr_ptr set to (owner_id+1) mod NUM_MASTERS. owner_id holds its last value.
- RELEASE:
  - Stay while b_util is high, i.e. the previous owner is still driving.
  - When b_util is low, go to IDLE.
  - Minimum 1 cycle, giving a guaranteed bus-turnaround gap of ≥1 cycle with no grant.
- Invariants:
  - m_grant is one-hot or zero; it is never multi-hot.
  - m_grant is nonzero exactly in GRANT_WAIT and OWNED.
- Simultaneous events:
  - Request drop beats b_util.
  - b_util beats timeout.
  - A new request arriving during RELEASE is served only after the return to IDLE.
- A request from a non-owner while the bus is owned is ignored and no grant is preempted.
- The same master re-requesting is re-granted if it is the only requester.
- timeout_err is high for exactly one cycle, the first cycle of RELEASE.

Test Plan:
1. Single grant (NUM_MASTERS=3): m_request=3'b010 with slave_busy=0 → m_grant=3'b010 and owner_id=1 one cycle later. Raise b_util, then drop request → m_grant=0 next edge; arb_busy falls 2 cycles after b_util goes low.
2. Round-robin: m_request=3'b111 held; each owner asserts b_util 4 cycles then drops and re-raises its request → grant sequence 001, 010, 100, 001, with ≥1 grant-free cycle between each.
3. Fixed priority (PRIORITY_MODE=1): m_request=3'b110, master1 repeats transactions → grant always 3'b010 and master2 starves. Drop master1 → 3'b100.
4. Grant timeout (TIMEOUT_LEN=4): m_request=3'b001, b_util held 0 → m_grant high exactly 16 cycles. timeout_err pulses once, then with 3'b011 requesting the next grant is 3'b010.
5. slave_busy gating: slave_busy=1, m_request=3'b100 for 10 cycles → no grant. slave_busy→0 → m_grant=3'b100 one cycle later.
6. Async reset mid-OWNED: rstn low between clock edges → m_grant=0, owner_id=0, arb_busy=0, timeout_err=0 immediately. After release, the first grant goes to the lowest requester (rr_ptr=0).

Source files
------------

// File: rtl/serial_bus_arbiter.sv
// Central arbiter for the shared serial bus.
// One-hot registered grant with idle watchdog and turnaround gap.
module serial_bus_arbiter #(
  parameter int NUM_MASTERS   = 3,
  parameter int TIMEOUT_LEN   = 6,
  parameter int PRIORITY_MODE = 0,
  localparam int IW = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic                   b_util,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [IW-1:0]          owner_id,
  output logic                   arb_busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_WAIT,
    OWNED,
    RELEASE
  } state_t;

  localparam logic [TIMEOUT_LEN-1:0] TMAX = '1;
  localparam logic [IW-1:0] LAST = IW'(NUM_MASTERS - 1);

  state_t                   state, state_nx;
  logic [NUM_MASTERS-1:0]   grant_nx;
  logic [IW-1:0]            owner_nx;
  logic [IW-1:0]            rr_ptr, rr_ptr_nx;
  logic [IW-1:0]            rr_inc;
  logic [IW-1:0]            win_id;
  logic [TIMEOUT_LEN-1:0]   count, count_nx;
  logic                     terr_nx;
  logic                     owner_req;

  assign arb_busy  = (state != IDLE);
  assign owner_req = m_request[owner_id];
  assign rr_inc    = (owner_id == LAST) ? '0 : owner_id + 1'b1;

  // Pick the winner: lowest index, or first at/after rr_ptr.
  always_comb begin
    int idx;
    idx    = 0;
    win_id = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (PRIORITY_MODE == 1) idx = i;
      else idx = (int'(rr_ptr) + i) % NUM_MASTERS;
      if (m_request[idx]) win_id = IW'(idx);
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nx  = state;
    grant_nx  = m_grant;
    owner_nx  = owner_id;
    rr_ptr_nx = rr_ptr;
    count_nx  = count;
    terr_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|m_request && !slave_busy) begin
          state_nx         = GRANT_WAIT;
          grant_nx         = '0;
          grant_nx[win_id] = 1'b1;
          owner_nx         = win_id;
          count_nx         = '0;
        end
      end
      GRANT_WAIT, OWNED: begin
        if (!owner_req) begin
          state_nx  = RELEASE;
          grant_nx  = '0;
          rr_ptr_nx = rr_inc;
        end else if (b_util) begin
          state_nx = OWNED;
          count_nx = '0;
        end else if (count == TMAX) begin
          state_nx  = RELEASE;
          grant_nx  = '0;
          rr_ptr_nx = rr_inc;
          terr_nx   = 1'b1;
        end else begin
          count_nx = count + 1'b1;
        end
      end
      RELEASE: begin
        if (!b_util) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      m_grant     <= '0;
      owner_id    <= '0;
      rr_ptr      <= '0;
      count       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      m_grant     <= grant_nx;
      owner_id    <= owner_nx;
      rr_ptr      <= rr_ptr_nx;
      count       <= count_nx;
      timeout_err <= terr_nx;
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter.
// Round-robin and fixed-priority instances, both TIMEOUT_LEN=4.
module tb_serial_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] m_request;
  logic       b_util;
  logic       slave_busy;
  logic [2:0] m_grant;
  logic [1:0] owner_id;
  logic       arb_busy;
  logic       timeout_err;

  logic [2:0] req_p;
  logic       util_p;
  logic [2:0] grant_p;
  logic [1:0] owner_p;
  logic       busy_p;
  logic       terr_p;

  int nerr = 0;
  int nchk = 0;
  int cyc;
  logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  serial_bus_arbiter #(
    .NUM_MASTERS(3),
    .TIMEOUT_LEN(4),
    .PRIORITY_MODE(0)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .m_request(m_request),
    .b_util(b_util),
    .slave_busy(slave_busy),
    .m_grant(m_grant),
    .owner_id(owner_id),
    .arb_busy(arb_busy),
    .timeout_err(timeout_err)
  );

  serial_bus_arbiter #(
    .NUM_MASTERS(3),
    .TIMEOUT_LEN(4),
    .PRIORITY_MODE(1)
  ) dutp (
    .clk(clk),
    .rstn(rstn),
    .m_request(req_p),
    .b_util(util_p),
    .slave_busy(slave_busy),
    .m_grant(grant_p),
    .owner_id(owner_p),
    .arb_busy(busy_p),
    .timeout_err(terr_p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    m_request  = '0;
    b_util     = 1'b0;
    slave_busy = 1'b0;
    req_p      = '0;
    util_p     = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(m_grant), 32'd0);
    chk("rst_owner", 32'(owner_id), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    rstn = 1'b1;

    // single grant, release after drop
    m_request = 3'b010;
    tick();
    chk("t1_grant", 32'(m_grant), 32'b010);
    chk("t1_owner", 32'(owner_id), 32'd1);
    chk("t1_busy", 32'(arb_busy), 32'd1);
    b_util = 1'b1;
    tick();
    chk("t1_owned", 32'(m_grant), 32'b010);
    m_request = '0;
    b_util    = 1'b0;
    tick();
    chk("t1_rel_grant", 32'(m_grant), 32'd0);
    chk("t1_rel_busy", 32'(arb_busy), 32'd1);
    chk("t1_rel_owner", 32'(owner_id), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(arb_busy), 32'd0);

    // round robin from a fresh rr_ptr
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_request = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant", 32'(m_grant), 32'(exp_g[k]));
      b_util = 1'b1;
      repeat (4) tick();
      chk("rr_hold", 32'(m_grant), 32'(exp_g[k]));
      m_request = 3'b111 & ~exp_g[k];
      b_util    = 1'b0;
      tick();
      chk("rr_gap1", 32'(m_grant), 32'd0);
      m_request = 3'b111;
      tick();
      chk("rr_gap2", 32'(m_grant), 32'd0);
    end
    m_request = '0;
    tick();
    tick();

    // grant watchdog: no bus activity
    m_request = 3'b001;
    tick();
    chk("to_grant", 32'(m_grant), 32'b001);
    cyc = 0;
    while (m_grant != 3'b000 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("to_len", 32'(cyc), 32'd16);
    chk("to_pulse", 32'(timeout_err), 32'd1);
    m_request = 3'b011;
    tick();
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    chk("to_idle", 32'(arb_busy), 32'd0);
    tick();
    chk("to_next", 32'(m_grant), 32'b010);

    // idle watchdog in OWNED
    b_util = 1'b1;
    tick();
    b_util = 1'b0;
    cyc = 0;
    while (m_grant != 3'b000 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("wd_len", 32'(cyc), 32'd16);
    chk("wd_pulse", 32'(timeout_err), 32'd1);
    m_request = '0;
    tick();

    // abandon in GRANT_WAIT: no error
    m_request = 3'b001;
    tick();
    chk("ab_grant", 32'(m_grant), 32'b001);
    m_request = '0;
    tick();
    chk("ab_rel", 32'(m_grant), 32'd0);
    chk("ab_terr", 32'(timeout_err), 32'd0);
    chk("ab_busy", 32'(arb_busy), 32'd1);
    tick();

    // slave_busy gating
    slave_busy = 1'b1;
    m_request  = 3'b100;
    repeat (10) tick();
    chk("sb_grant", 32'(m_grant), 32'd0);
    chk("sb_busy", 32'(arb_busy), 32'd0);
    slave_busy = 1'b0;
    tick();
    chk("sb_go", 32'(m_grant), 32'b100);
    chk("sb_owner", 32'(owner_id), 32'd2);
    b_util = 1'b1;
    tick();
    m_request = 3'b111;
    tick();
    chk("no_preempt", 32'(m_grant), 32'b100);

    // async reset mid-OWNED
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_grant", 32'(m_grant), 32'd0);
    chk("ar_owner", 32'(owner_id), 32'd0);
    chk("ar_busy", 32'(arb_busy), 32'd0);
    chk("ar_terr", 32'(timeout_err), 32'd0);
    m_request = 3'b110;
    b_util    = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
    chk("ar_first", 32'(m_grant), 32'b010);
    chk("ar_first_id", 32'(owner_id), 32'd1);

    // RELEASE holds while b_util stays high
    b_util = 1'b1;
    tick();
    m_request = '0;
    tick();
    chk("rh_grant", 32'(m_grant), 32'd0);
    tick();
    chk("rh_stay", 32'(arb_busy), 32'd1);
    b_util = 1'b0;
    tick();
    chk("rh_idle", 32'(arb_busy), 32'd0);

    // fixed priority: master1 starves master2
    req_p = 3'b110;
    tick();
    chk("fp_grant0", 32'(grant_p), 32'b010);
    for (int k = 0; k < 2; k++) begin
      util_p = 1'b1;
      tick();
      req_p  = 3'b100;
      util_p = 1'b0;
      tick();
      chk("fp_gap", 32'(grant_p), 32'd0);
      req_p = 3'b110;
      tick();
      tick();
      chk("fp_regrant", 32'(grant_p), 32'b010);
    end
    req_p = 3'b100;
    tick();
    tick();
    tick();
    chk("fp_m2", 32'(grant_p), 32'b100);
    chk("fp_m2_id", 32'(owner_p), 32'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
